// File: rtl/jogo_pkg.sv
// Shared state codes and constants for the sequence-memory game control unit.
package jogo_pkg;

    localparam int ESTADO_W  = 4;
    localparam int N_RODADAS = 16;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARA        = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        GANHOU         = 4'hA,
        PERDEU         = 4'hC,
        TIMEOUT        = 4'hE
    } estado_t;

    // Terminal states are the ones that report a finished game.
    function automatic logic estado_final(input estado_t e);
        logic r;
        case (e)
            GANHOU, PERDEU, TIMEOUT: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Per-play timeout counter: counts while enabled, flags the last allowed cycle.
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    localparam int W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [W-1:0] ULTIMO = W'(TIMEOUT_CICLOS - 1);

    logic [W-1:0] conta_q;
    logic [W-1:0] conta_d;

    // Next count: clear has priority over counting.
    always_comb begin
        conta_d = conta_q;
        if (clear) begin
            conta_d = {W{1'b0}};
        end else if (enable) begin
            conta_d = conta_q + W'(1);
        end else begin
            conta_d = conta_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conta_q <= {W{1'b0}};
        end else begin
            conta_q <= conta_d;
        end
    end

    assign fim = enable && (conta_q == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore control FSM of the sequence-memory game.
// Build option JOGO_TIMEOUT_EN adds the per-play timeout counter and TIMEOUT state.
module unidade_controle_jogo
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim_rodada,
    input  logic       fim_jogo,
    output logic       zera_rodada,
    output logic       conta_rodada,
    output logic       zera_endereco,
    output logic       conta_endereco,
    output logic       registra_jogada,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    estado_t estado_q;
    estado_t estado_d;
    logic    timeout_s;

`ifdef JOGO_TIMEOUT_EN
    contador_timeout #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .clear (estado_q != ESPERA_JOGADA),
        .enable(estado_q == ESPERA_JOGADA),
        .fim   (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic; a press arriving together with the timeout wins.
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:        estado_d = jogar ? PREPARA : INICIAL;
            PREPARA:        estado_d = INICIO_RODADA;
            INICIO_RODADA:  estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada) begin
                    estado_d = REGISTRA;
                end else if (timeout_s) begin
                    estado_d = TIMEOUT;
                end else begin
                    estado_d = ESPERA_JOGADA;
                end
            end
            REGISTRA:       estado_d = COMPARA;
            COMPARA: begin
                if (!igual) begin
                    estado_d = PERDEU;
                end else if (!fim_rodada) begin
                    estado_d = PROXIMA_JOGADA;
                end else if (!fim_jogo) begin
                    estado_d = PROXIMA_RODADA;
                end else begin
                    estado_d = GANHOU;
                end
            end
            PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_d = INICIO_RODADA;
`ifdef JOGO_TIMEOUT_EN
            GANHOU, PERDEU, TIMEOUT: estado_d = jogar ? PREPARA : estado_q;
`else
            GANHOU, PERDEU: estado_d = jogar ? PREPARA : estado_q;
`endif
            default:        estado_d = INICIAL;
        endcase
    end

    // Output decode from the current state only.
    always_comb begin
        zera_rodada     = (estado_q == PREPARA);
        conta_rodada    = (estado_q == PROXIMA_RODADA);
        zera_endereco   = (estado_q == PREPARA) || (estado_q == INICIO_RODADA);
        conta_endereco  = (estado_q == PROXIMA_JOGADA);
        registra_jogada = (estado_q == REGISTRA);
        ganhou          = (estado_q == GANHOU);
        pronto          = estado_final(estado_q);
        db_estado       = estado_q;
`ifdef JOGO_TIMEOUT_EN
        perdeu          = (estado_q == PERDEU) || (estado_q == TIMEOUT);
        db_timeout      = (estado_q == TIMEOUT);
`else
        perdeu          = (estado_q == PERDEU);
        db_timeout      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Randomized and directed bench for unidade_controle_jogo against a behavioural game model.
module tb_unidade_controle_jogo;

    localparam int TC = 10;
`ifdef JOGO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic jogar = 1'b0;
    logic jogada = 1'b0;
    logic igual = 1'b0;
    logic fim_rodada;
    logic fim_jogo;
    logic zera_rodada, conta_rodada, zera_endereco, conta_endereco, registra_jogada;
    logic ganhou, perdeu, pronto, db_timeout;
    logic [3:0] db_estado;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model state and player-side datapath.
    int m_est = 0;
    int m_wait = 0;
    logic [3:0] rodada = 4'd0;
    logic [3:0] endereco = 4'd0;
    bit use_dp = 1'b1;
    bit r_fr = 1'b0;
    bit r_fj = 1'b0;

    unidade_controle_jogo #(.TIMEOUT_CICLOS(TC)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .jogada(jogada), .igual(igual),
        .fim_rodada(fim_rodada), .fim_jogo(fim_jogo),
        .zera_rodada(zera_rodada), .conta_rodada(conta_rodada),
        .zera_endereco(zera_endereco), .conta_endereco(conta_endereco),
        .registra_jogada(registra_jogada), .ganhou(ganhou), .perdeu(perdeu),
        .pronto(pronto), .db_timeout(db_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    logic [12:0] dut_v;
    assign dut_v = {zera_rodada, conta_rodada, zera_endereco, conta_endereco, registra_jogada,
                    ganhou, perdeu, pronto, db_timeout, db_estado};

    always @* begin
        fim_rodada = use_dp ? (endereco == rodada) : r_fr;
        fim_jogo   = use_dp ? (rodada == 4'd15) : r_fj;
    end

    // Game rules as a transition table on state codes.
    function automatic int nxt(input int e, input logic jg, input logic jd, input logic ig,
                               input logic fr, input logic fj, input int w);
        case (e)
            0: return jg ? 1 : 0;
            1: return 2;
            2: return 3;
            3: if (jd) return 4; else if (TO_EN && w == TC - 1) return 14; else return 3;
            4: return 5;
            5: if (!ig) return 12; else if (!fr) return 6; else if (!fj) return 7; else return 10;
            6: return 3;
            7: return 2;
            10, 12: return jg ? 1 : e;
            14: return TO_EN ? (jg ? 1 : 14) : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [12:0] expv(input int e);
        logic [3:0] c;
        c = e[3:0];
        return {e == 1, e == 7, (e == 1) || (e == 2), e == 6, e == 4, e == 10,
                (e == 12) || (e == 14), (e == 10) || (e == 12) || (e == 14), e == 14, c};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_est  <= 0;
            m_wait <= 0;
        end else begin
            m_est  <= nxt(m_est, jogar, jogada, igual, fim_rodada, fim_jogo, m_wait);
            m_wait <= (m_est == 3 && nxt(m_est, jogar, jogada, igual, fim_rodada, fim_jogo, m_wait) == 3)
                      ? m_wait + 1 : 0;
        end
    end

    always @(posedge clock) begin
        if (m_est == 1) rodada <= 4'd0;
        else if (m_est == 7) rodada <= rodada + 4'd1;
        if (m_est == 1 || m_est == 2) endereco <= 4'd0;
        else if (m_est == 6) endereco <= endereco + 4'd1;
    end

    // Advance one cycle and compare every DUT output with the model.
    task automatic tick();
        @(negedge clock);
        n_tests++;
        if (dut_v !== expv(m_est)) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, dut_v, expv(m_est));
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", nm, act, req);
        end
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        tick();
        #1 reset = 1'b0;
    endtask

    task automatic wait_est(input int code);
        int k;
        k = 0;
        while (m_est != code && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_state got=%0d expected=%0d", m_est, code);
        end
    endtask

    task automatic play(input logic ig);
        wait_est(3);
        jogada = 1'b1;
        igual  = ig;
        tick();
        jogada = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int plays;
        #1 reset = 1'b1;
        repeat (2) tick();
        #1 reset = 1'b0;
        chk("reset_estado", {12'd0, db_estado}, 16'h0000);
        chk("reset_outs", {3'd0, dut_v}, 16'h0000);

        // First round: trace 1,2,3,4,5,7,2.
        jogar = 1'b1; tick(); jogar = 1'b0;
        chk("tr_prepara", {12'd0, db_estado}, 16'h1);
        tick(); chk("tr_inicio", {12'd0, db_estado}, 16'h2);
        tick(); chk("tr_espera", {12'd0, db_estado}, 16'h3);
        jogada = 1'b1; igual = 1'b1; tick(); jogada = 1'b0;
        chk("tr_registra", {12'd0, db_estado}, 16'h4);
        tick(); chk("tr_compara", {12'd0, db_estado}, 16'h5);
        tick(); chk("tr_prox_rod", {12'd0, db_estado}, 16'h7);
        chk("tr_conta_rod", {15'd0, conta_rodada}, 16'h1);
        tick(); chk("tr_inicio2", {12'd0, db_estado}, 16'h2);
        chk("tr_conta_rod0", {15'd0, conta_rodada}, 16'h0);

        // Complete all 16 rounds.
        plays = 1;
        while (m_est != 10 && plays < 300) begin
            play(1'b1);
            plays++;
        end
        chk("win_plays", 16'(plays), 16'd136);
        chk("win_estado", {12'd0, db_estado}, 16'hA);
        chk("win_flags", {13'd0, ganhou, pronto, perdeu}, 16'b110);
        repeat (100) tick();
        chk("win_held", {11'd0, db_estado, ganhou}, {11'd0, 4'hA, 1'b1});

        // Restart from GANHOU holding jogar through the game, then lose in round 2.
        jogar = 1'b1; tick();
        chk("restart_a", {12'd0, db_estado}, 16'h1);
        chk("restart_flags", {13'd0, ganhou, pronto, perdeu}, 16'b000);
        play(1'b1); play(1'b1); play(1'b1);
        jogar = 1'b0;
        play(1'b1); play(1'b0);
        chk("lose_estado", {12'd0, db_estado}, 16'hC);
        chk("lose_flags", {12'd0, ganhou, perdeu, pronto, db_timeout}, 16'b0110);

        jogar = 1'b1; tick(); jogar = 1'b0;
        chk("restart_c", {12'd0, db_estado}, 16'h1);
        wait_est(3);
`ifdef JOGO_TIMEOUT_EN
        repeat (TC - 1) tick();
        chk("to_last_wait", {12'd0, db_estado}, 16'h3);
        tick();
        chk("to_estado", {12'd0, db_estado}, 16'hE);
        chk("to_flags", {12'd0, perdeu, db_timeout, pronto, ganhou}, 16'b1110);
        jogar = 1'b1; tick(); jogar = 1'b0;
        chk("restart_e", {12'd0, db_estado}, 16'h1);
        wait_est(3);
        repeat (TC - 1) tick();
        jogada = 1'b1; igual = 1'b1; tick(); jogada = 1'b0;
        chk("to_prio", {12'd0, db_estado}, 16'h4);
`else
        repeat (200) tick();
        chk("no_to_wait", {12'd0, db_estado}, 16'h3);
`endif

        // Reset in the middle of a wait.
        wait_est(3);
        repeat (5) tick();
        do_reset();
        tick();
        chk("rst_mid_estado", {12'd0, db_estado}, 16'h0);
        chk("rst_mid_outs", {3'd0, dut_v}, 16'h0000);
`ifdef JOGO_TIMEOUT_EN
        jogar = 1'b1; tick(); jogar = 1'b0;
        wait_est(3);
        repeat (TC - 1) tick();
        chk("rst_cnt_wait", {12'd0, db_estado}, 16'h3);
        tick();
        chk("rst_cnt_to", {12'd0, db_estado}, 16'hE);
`endif

        // Random inputs, including illegal combinations and stray presses.
        use_dp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            jogar  = ($urandom_range(0, 15) == 0);
            jogada = ($urandom_range(0, 3) == 0);
            igual  = ($urandom_range(0, 7) != 0);
            r_fr   = ($urandom_range(0, 2) == 0);
            r_fj   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
